// File: rtl/pulse_echo_chk_pkg.sv
// Shared types and constants for the pulse-echo checker.
package pulse_echo_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    WAIT    = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam logic [2:0] FC_NONE   = 3'd0;
  localparam logic [2:0] FC_EARLY  = 3'd1;
  localparam logic [2:0] FC_LATE   = 3'd2;
  localparam logic [2:0] FC_SPUR   = 3'd3;
  localparam logic [2:0] FC_RETRIG = 3'd4;
  localparam logic [2:0] FC_OVF    = 3'd5;

endpackage

// File: rtl/pulse_echo_checker_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  // Count up on inc, holding at all-ones.
  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) q_d = q_q + WIDTH'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pulse_echo_checker.sv
// Monitors a pulse-echo stage: measures each a-pulse width W and checks
// that b rises exactly W cycles after a falls.
module pulse_echo_checker
  import pulse_echo_chk_pkg::*;
#(
  parameter int unsigned W_W   = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             pass,
  output logic             fail,
  output logic [2:0]       fail_code,
  output logic [W_W-1:0]   last_width,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             busy
);

  state_e           state_d, state_q;
  logic [W_W-1:0]   timer_d, timer_q;
  logic [W_W-1:0]   last_width_d, last_width_q;
  logic             pass_d, pass_q;
  logic             fail_d, fail_q;
  logic [2:0]       fail_code_d, fail_code_q;
  logic [2:0]       fc;
  logic [W_W-1:0]   width;
  logic [W_W-1:0]   k;
  logic             width_inc, width_clr, width_rst;

  // The width counter is cleared whenever a measurement ends, so it always
  // sits at zero outside MEASURE; a single inc then yields width = 1.
  assign width_rst = rst | width_clr;
  assign k         = timer_q + W_W'(1);

  sat_counter #(.WIDTH(W_W)) u_width (
    .clk (clk),
    .rst (width_rst),
    .inc (width_inc),
    .q   (width)
  );

  sat_counter #(.WIDTH(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pass_d),
    .q   (pass_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .inc (fail_d),
    .q   (fail_count)
  );

  // Next-state and verdict logic; fc carries the single highest-priority fault.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_width_d = last_width_q;
    pass_d       = 1'b0;
    fail_d       = 1'b0;
    fail_code_d  = fail_code_q;
    fc           = FC_NONE;
    width_inc    = 1'b0;
    width_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (b) fc = FC_SPUR;
        if (a) begin
          state_d   = MEASURE;
          width_inc = 1'b1;
        end
      end
      MEASURE: begin
        if (a) begin
          if (width == '1) begin
            fc        = FC_OVF;
            state_d   = DRAIN;
            width_clr = 1'b1;
          end else begin
            width_inc = 1'b1;
            if (b) fc = FC_SPUR;
          end
        end else begin
          last_width_d = width;
          width_clr    = 1'b1;
          timer_d      = '0;
          if (b) begin
            fc      = FC_EARLY;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        timer_d = k;
        // A b decision (or the LATE deadline) outranks RETRIG; a still high on
        // that edge starts a fresh measurement without reporting RETRIG.
        if (b || (k == last_width_q)) begin
          if (b && (k == last_width_q)) pass_d = 1'b1;
          else if (b)                   fc     = FC_EARLY;
          else                          fc     = FC_LATE;
          state_d   = a ? MEASURE : IDLE;
          width_inc = a;
        end else if (a) begin
          fc        = FC_RETRIG;
          state_d   = MEASURE;
          width_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (!a) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fc != FC_NONE) begin
      fail_d      = 1'b1;
      fail_code_d = fc;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      last_width_q <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FC_NONE;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_width_q <= last_width_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      fail_code_q  <= fail_code_d;
    end
  end

  assign pass       = pass_q;
  assign fail       = fail_q;
  assign fail_code  = fail_code_q;
  assign last_width = last_width_q;
  assign busy       = (state_q == MEASURE) || (state_q == WAIT);

endmodule

// File: tb/tb_pulse_echo_checker.sv
// Directed scoreboard bench for pulse_echo_checker (W_W=8 and W_W=3 instances).
module tb_pulse_echo_checker;

  localparam int EV_PASS = 8;

  typedef struct {
    logic       pass;
    logic       fail;
    logic [2:0] code;
    logic [7:0] lw;
    logic [7:0] pc;
    logic [7:0] fc;
    logic       busy;
    int         d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, a3 = 1'b0, b3 = 1'b0;
  logic       pass8, fail8, busy8, pass3, fail3, busy3;
  logic [2:0] code8, code3;
  logic [7:0] lw8, pc8, fc8, pc3, fc3;
  logic [2:0] lw3;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_pc[2], exp_fc[2], exp_lw[2];
  logic [2:0] exp_code[2];

  always #5 clk = ~clk;

  pulse_echo_checker #(.W_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .pass(pass8), .fail(fail8),
    .fail_code(code8), .last_width(lw8), .pass_count(pc8),
    .fail_count(fc8), .busy(busy8)
  );

  pulse_echo_checker #(.W_W(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .a(a3), .b(b3), .pass(pass3), .fail(fail3),
    .fail_code(code3), .last_width(lw3), .pass_count(pc3),
    .fail_count(fc3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Drive one edge worth of stimulus, push expectation, then pop and compare.
  task automatic step(input int d, input logic r, input logic ai, input logic bi,
                      input int ev, input logic bz);
    exp_t e;
    rst = r;
    a  = (d == 0) ? ai : 1'b0;
    b  = (d == 0) ? bi : 1'b0;
    a3 = (d == 1) ? ai : 1'b0;
    b3 = (d == 1) ? bi : 1'b0;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        exp_pc[i] = '0; exp_fc[i] = '0; exp_lw[i] = '0; exp_code[i] = '0;
      end
    end else if (ev == EV_PASS) begin
      if (exp_pc[d] != 8'hff) exp_pc[d] = exp_pc[d] + 8'd1;
    end else if (ev != 0) begin
      if (exp_fc[d] != 8'hff) exp_fc[d] = exp_fc[d] + 8'd1;
      exp_code[d] = 3'(ev);
    end
    e.pass = (ev == EV_PASS);
    e.fail = (ev >= 1) && (ev <= 5);
    e.code = exp_code[d];
    e.lw   = exp_lw[d];
    e.pc   = exp_pc[d];
    e.fc   = exp_fc[d];
    e.busy = bz;
    e.d    = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.d == 0) begin
      chk("pass8", {7'd0, pass8}, {7'd0, e.pass});
      chk("fail8", {7'd0, fail8}, {7'd0, e.fail});
      chk("code8", {5'd0, code8}, {5'd0, e.code});
      chk("lw8",   lw8, e.lw);
      chk("pc8",   pc8, e.pc);
      chk("fc8",   fc8, e.fc);
      chk("busy8", {7'd0, busy8}, {7'd0, e.busy});
    end else begin
      chk("pass3", {7'd0, pass3}, {7'd0, e.pass});
      chk("fail3", {7'd0, fail3}, {7'd0, e.fail});
      chk("code3", {5'd0, code3}, {5'd0, e.code});
      chk("lw3",   {5'd0, lw3}, e.lw);
      chk("pc3",   pc3, e.pc);
      chk("fc3",   fc3, e.fc);
      chk("busy3", {7'd0, busy3}, {7'd0, e.busy});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // on-time echo: W=3, b at t0+3
    repeat (3) step(0, 0, 1, 0, 0, 1);
    exp_lw[0] = 8'd3;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, EV_PASS, 0);
    step(0, 0, 0, 0, 0, 0);

    // early echo then spurious b in IDLE
    repeat (4) step(0, 0, 1, 0, 0, 1);
    exp_lw[0] = 8'd4;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0, 0);

    // missing echo: LATE at t0+2
    repeat (2) step(0, 0, 1, 0, 0, 1);
    exp_lw[0] = 8'd2;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0);

    // retrigger during WAIT, then on-time echo of the 1-cycle pulse
    repeat (5) step(0, 0, 1, 0, 0, 1);
    exp_lw[0] = 8'd5;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 4, 1);
    exp_lw[0] = 8'd1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, EV_PASS, 0);

    // a and b together at the decision edge: pass, no RETRIG, re-measure
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, EV_PASS, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, EV_PASS, 0);

    // b at t0 itself is EARLY
    step(0, 0, 1, 0, 0, 1);
    exp_lw[0] = 8'd1;
    step(0, 0, 0, 1, 1, 0);

    // b during MEASURE is SPURIOUS, measurement continues
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 3, 1);
    exp_lw[0] = 8'd2;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, EV_PASS, 0);

    // reset mid-WAIT with b high: silent abandon
    repeat (3) step(0, 0, 1, 0, 0, 1);
    exp_lw[0] = 8'd3;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // pass counter saturation
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 1, 0, 0, 1);
      exp_lw[0] = 8'd1;
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, EV_PASS, 0);
    end
    step(0, 0, 0, 0, 0, 0);

    // W_W=3 overflow and drain
    step(1, 1, 0, 0, 0, 0);
    repeat (7) step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 5, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, 1, 0, 0, 1);
    exp_lw[1] = 8'd2;
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, EV_PASS, 0);
    step(1, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_echo_checker.md
Name: pulse_echo_checker

Overview:
- Downstream monitor for the pulse-echo stage, which measures how long its input `a` stays high and later answers with a pulse on `b`.
- This block samples the stage's input `a` and its output `b`.
- It measures each `a` high-pulse width W, then checks that `b` rises exactly W cycles after `a` falls.
- It reports a pass/fail pulse, a fail code and saturating event counts, for ABV-style bench checking and on-chip self-test.

Parameters:
- W_W, 8, width of the pulse-width measurement and timer.
- CNT_W, 8, width of the pass/fail event counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high; sampled on the rising edge of clk.
- a  in  1  observed stimulus (the echo stage's input).
- b  in  1  observed response (the echo stage's output).
- pass  out  1  one-cycle pulse: echo arrived on time.
- fail  out  1  one-cycle pulse: protocol violation.
- fail_code  out  3  cause of the latest fail; held until the next fail.
- last_width  out  W_W  width W of the most recently completed a-pulse.
- pass_count  out  CNT_W  saturating count of passes.
- fail_count  out  CNT_W  saturating count of fails.
- busy  out  1  high in MEASURE or WAIT.

Behaviour:
- Reset values: state = IDLE; pass, fail and busy = 0; fail_code = 0; last_width = 0; pass_count = 0; fail_count = 0; width and timer = 0.
- Reset mid-operation abandons the measurement silently: no pass or fail is issued.
- All inputs are sampled on the clk rising edge. pass and fail are registered and assert on the edge of the deciding sample.
- Fail codes: 1 EARLY, 2 LATE, 3 SPURIOUS, 4 RETRIG, 5 OVERFLOW.
- IDLE:
  - a=1 → MEASURE, width = 1.
  - b=1 (with any a) → fail SPURIOUS; stays IDLE unless a=1 on the same edge.
- MEASURE:
  - a=1 → width += 1.
  - If width is already 2^W_W−1 → fail OVERFLOW, then go to IDLE and ignore a until it is sampled low (DRAIN sub-state).
  - a=0 → call this edge t0; go to WAIT, timer = 0, last_width = width.
  - b=1 in MEASURE → fail SPURIOUS; measurement continues.
- WAIT (timer increments on each edge after t0; k = timer+1 at the edge being evaluated):
  - b=1 with k < W → fail EARLY, → IDLE.
  - b=1 with k = W → pass, → IDLE.
  - b=0 with k = W → fail LATE, → IDLE. This is a missing echo; no later check.
  - a=1 before decision → fail RETRIG, → MEASURE with width = 1.
  - a=1 and b=1 on the same edge → the b check is evaluated first; the RETRIG fail is not raised; the state then goes to MEASURE with width = 1.
- b=1 at t0 itself counts as EARLY.
- At most one of pass or fail is asserted per cycle. If two faults coincide, priority is OVERFLOW > EARLY/LATE > RETRIG > SPURIOUS.
- pass_count and fail_count increment with their pulses and saturate at all-ones; they never wrap.
- busy = (state is MEASURE or WAIT).
- All arithmetic is unsigned W_W-bit; width and timer are compared for equality only.

Decomposition:
- Package pulse_echo_chk_pkg holds:
  - the state enum: IDLE, MEASURE, WAIT, DRAIN;
  - the fail-code localparams: FC_NONE=0, FC_EARLY=1, FC_LATE=2, FC_SPUR=3, FC_RETRIG=4, FC_OVF=5.
- Sub-module sat_counter (parameter WIDTH; inputs clk, rst, inc; output q) is instantiated three times:
  - the width measurement, with overflow flagged by q == max;
  - pass_count;
  - fail_count.
- The WAIT timer is a plain register in the top module.

Test Plan:
- a high for 3 edges, then low (t0); b=1 at edge t0+3 only → pass=1 at that edge; last_width=3; pass_count=1; fail_count=0; busy falls the following cycle.
- a high for 4 edges; b=1 at t0+2 → fail=1, fail_code=1 (EARLY), fail_count=1; b=1 at t0+4 then gives fail=1, fail_code=3 (SPURIOUS), fail_count=2.
- a high for 2 edges; b held 0 → fail=1 with fail_code=2 (LATE) at t0+2; state IDLE; pass_count unchanged.
- a high 5 edges; at t0+2 a rises again for 1 edge, then b=1 at (new t0)+1:
  - at t0+2: fail_code=4 (RETRIG);
  - at (new t0)+1: pass=1, last_width=1;
  - counts: pass_count=1, fail_count=1.
- W_W=3: a high for 8 edges → fail_code=5 (OVERFLOW) at the 8th edge; further a-high edges produce nothing until a is sampled low; a b pulse is ignored by the drain.
- Assert rst for 1 cycle mid-WAIT, then drive b=1 → no pass or fail; all outputs at reset values; 255 forced passes with CNT_W=8 leave pass_count=255 (saturated).
